// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and
// baud-divider helpers used by the receiver and the planned transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic int calc_tick_div(input int clk_freq, input int baud_rate,
                                       input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick divider: one-cycle tick every DIV clocks, restartable
// with a synchronous clear so the sample phase can be aligned to an edge.
module uart_tick_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with 3-sample majority bit detection, parity,
// framing, break and overrun status, and a one-entry valid/ready holding register.
module uart_rx_frame #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);
  import uart_pkg::*;

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] T_S0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] T_S1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] T_DEC  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] T_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_DONE = BW'(DATA_BITS);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == PAR_ODD);
  localparam logic HAS_PAR = (PARITY != PAR_NONE);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_frame: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_frame: OVERSAMPLE must be even, 8..16");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_frame: PARITY must be 0, 1 or 2");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("uart_rx_frame: TICK_DIV must be at least 2");
  end

  rx_state_t             state;
  logic                  rx_meta, rx_sync, rx_prev;
  logic                  tick, tick_clear;
  logic [SW-1:0]         sample_cnt;
  logic                  s0, s1;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  parity_bit;
  logic                  stop_err;
  logic                  start_edge, bit_val, at_dec, at_end;
  logic                  exp_parity, is_break, load_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Divider is parked while waiting for a start edge so tick 0 lands one tick after it.
  assign tick_clear = (state == ST_IDLE) || (state == ST_BREAK);

  uart_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(tick_clear),
    .tick (tick)
  );

  assign start_edge = rx_prev & ~rx_sync;
  assign bit_val    = majority3(s0, s1, rx_sync);
  assign at_dec     = tick && (sample_cnt == T_DEC);
  assign at_end     = tick && (sample_cnt == T_LAST);
  assign exp_parity = (^shift_reg) ^ ODD;
  assign is_break   = (shift_reg == '0) && !parity_bit && !bit_val;
  assign load_ok    = !valid || ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      stop_err   <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      if (tick) begin
        sample_cnt <= (sample_cnt == T_LAST) ? '0 : sample_cnt + SW'(1);
        if (sample_cnt == T_S0) s0 <= rx_sync;
        if (sample_cnt == T_S1) s1 <= rx_sync;
      end

      case (state)
        ST_IDLE: begin
          sample_cnt <= '0;
          if (start_edge) begin
            state      <= ST_START;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            stop_err   <= 1'b0;
          end
        end
        ST_START: begin
          if (at_dec && bit_val) state <= ST_IDLE;
          else if (at_end) state <= ST_DATA;
        end
        ST_DATA: begin
          if (at_dec) begin
            shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= bit_idx + BW'(1);
          end
          if (at_end && bit_idx == BITS_DONE) begin
            state <= HAS_PAR ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (at_dec) parity_bit <= bit_val;
          if (at_end) state <= ST_STOP;
        end
        ST_STOP: begin
          if (at_dec) begin
            if (!stop_idx && is_break) begin
              break_det <= 1'b1;
              state     <= ST_BREAK;
            end else if (stop_idx == STOP_LAST) begin
              // Frame completes mid stop bit; the rest of the bit is never waited for.
              state <= ST_IDLE;
              if (load_ok) begin
                data       <= shift_reg;
                valid      <= 1'b1;
                parity_err <= HAS_PAR && (parity_bit != exp_parity);
                frame_err  <= stop_err | ~bit_val;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              stop_err <= ~bit_val;
              stop_idx <= 1'b1;
            end
          end
        end
        ST_BREAK: begin
          sample_cnt <= '0;
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed self-checking bench for uart_rx_frame: 8N1, 8E1 and 5-bit/2-stop
// instances driven with hand-built serial frames at 96 clocks per bit.
module tb_uart_rx_frame;
  import uart_pkg::*;

  // 11.1 MHz / (115200*16) = 6.02 -> TICK_DIV 6, so one bit is 96 clocks.
  localparam int CLKF = 11_100_000;
  localparam int BIT  = 96;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       rx_m = 1'b1, ready_m = 1'b1;
  logic [7:0] data_m;
  logic       valid_m, pe_m, fe_m, ovr_m, brk_m;

  logic       rx_p = 1'b1, ready_p = 1'b1;
  logic [7:0] data_p;
  logic       valid_p, pe_p, fe_p, ovr_p, brk_p;

  logic       rx_f = 1'b1, ready_f = 1'b1;
  logic [4:0] data_f;
  logic       valid_f, pe_f, fe_f, ovr_f, brk_f;

  uart_rx_frame #(.CLK_FREQ(CLKF), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(16)) u_main (
    .clk(clk), .rst(rst), .rx(rx_m), .data(data_m), .valid(valid_m), .ready(ready_m),
    .parity_err(pe_m), .frame_err(fe_m), .overrun(ovr_m), .break_det(brk_m));

  uart_rx_frame #(.CLK_FREQ(CLKF), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .OVERSAMPLE(16)) u_par (
    .clk(clk), .rst(rst), .rx(rx_p), .data(data_p), .valid(valid_p), .ready(ready_p),
    .parity_err(pe_p), .frame_err(fe_p), .overrun(ovr_p), .break_det(brk_p));

  uart_rx_frame #(.CLK_FREQ(CLKF), .BAUD_RATE(115200), .DATA_BITS(5), .PARITY(0),
                  .STOP_BITS(2), .OVERSAMPLE(16)) u_five (
    .clk(clk), .rst(rst), .rx(rx_f), .data(data_f), .valid(valid_f), .ready(ready_f),
    .parity_err(pe_f), .frame_err(fe_f), .overrun(ovr_f), .break_det(brk_f));

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int t_start = 0;

  int rise_m = 0, vhi_m = 0, acc_m = 0, ovr_cnt_m = 0, brk_cnt_m = 0;
  logic vprev_m = 1'b0;
  logic [7:0] last_d_m = '0;
  logic last_pe_m = 1'b0, last_fe_m = 1'b0;
  int acc_p = 0;
  logic [7:0] last_d_p = '0;
  logic last_pe_p = 1'b0, last_fe_p = 1'b0;
  int acc_f = 0;
  logic [4:0] last_d_f = '0;
  logic last_fe_f = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observers record what each consumer accepted, sampled mid-cycle.
  always @(negedge clk) begin
    vprev_m <= valid_m;
    if (valid_m && !vprev_m) rise_m <= cyc;
    if (valid_m) vhi_m <= vhi_m + 1;
    if (valid_m && ready_m) begin
      acc_m     <= acc_m + 1;
      last_d_m  <= data_m;
      last_pe_m <= pe_m;
      last_fe_m <= fe_m;
    end
    if (ovr_m) ovr_cnt_m <= ovr_cnt_m + 1;
    if (brk_m) brk_cnt_m <= brk_cnt_m + 1;
    if (valid_p && ready_p) begin
      acc_p     <= acc_p + 1;
      last_d_p  <= data_p;
      last_pe_p <= pe_p;
      last_fe_p <= fe_p;
    end
    if (valid_f && ready_f) begin
      acc_f     <= acc_f + 1;
      last_d_f  <= data_f;
      last_fe_f <= fe_f;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: rx_m = v;
      1: rx_p = v;
      default: rx_f = v;
    endcase
  endtask

  // Holds one bit for a full bit period; the optional glitch covers only the middle sample.
  task automatic hold_bit(input int sel, input logic v, input logic glitch);
    set_line(sel, v);
    for (int c = 0; c < BIT; c++) begin
      @(negedge clk);
      if (glitch && c == 53) set_line(sel, ~v);
      if (glitch && c == 57) set_line(sel, v);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [8:0] word, input int nbits,
                               input int par, input int nstop, input logic [1:0] stop_vals,
                               input int glitch_bit);
    if (sel == 0) t_start = cyc;
    hold_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(sel, word[i], 1'(glitch_bit == i));
    if (par >= 0) hold_bit(sel, par[0], 1'b0);
    for (int i = 0; i < nstop; i++) hold_bit(sel, stop_vals[i], 1'b0);
  endtask

  task automatic idle_bits(input int sel, input int n);
    for (int i = 0; i < n; i++) hold_bit(sel, 1'b1, 1'b0);
  endtask

  initial begin
    int a0, v0, o0, b0, ap0, af0;
    logic in_window;

    repeat (5) @(negedge clk);
    checkOutput("reset_data", 16'(data_m), 16'h0000);
    checkOutput("reset_valid", 16'(valid_m), 16'h0000);
    checkOutput("reset_parity_err", 16'(pe_m), 16'h0000);
    checkOutput("reset_frame_err", 16'(fe_m), 16'h0000);
    checkOutput("reset_overrun", 16'(ovr_m), 16'h0000);
    checkOutput("reset_break", 16'(brk_m), 16'h0000);
    rst = 1'b1;
    idle_bits(0, 2);

    $display("[TB] 0xA5 8N1, ready high");
    a0 = acc_m; v0 = vhi_m;
    applyStimulus(0, 9'h0A5, 8, -1, 1, 2'b11, -1);
    idle_bits(0, 1);
    checkOutput("a5_accepts", 16'(acc_m - a0), 16'd1);
    checkOutput("a5_data", 16'(last_d_m), 16'h00A5);
    checkOutput("a5_flags", 16'({last_pe_m, last_fe_m}), 16'h0000);
    checkOutput("a5_valid_cycles", 16'(vhi_m - v0), 16'd1);
    // Last stop-bit decision falls between 9.5 and 10 bit periods after the start edge.
    in_window = (rise_m - t_start >= 912) && (rise_m - t_start <= 960);
    checkOutput("a5_latency_window", 16'(in_window), 16'd1);

    $display("[TB] 3-clock glitch on idle line");
    a0 = acc_m; v0 = vhi_m;
    rx_m = 1'b0;
    repeat (3) @(negedge clk);
    rx_m = 1'b1;
    idle_bits(0, 2);
    checkOutput("glitch_no_valid", 16'(vhi_m - v0), 16'd0);
    checkOutput("glitch_state_idle", 16'(u_main.state), 16'(ST_IDLE));

    $display("[TB] 0xF0 with one corrupted sample in bit 2");
    applyStimulus(0, 9'h0F0, 8, -1, 1, 2'b11, 2);
    idle_bits(0, 1);
    checkOutput("majority_data", 16'(last_d_m), 16'h00F0);

    $display("[TB] 0x3C with stop bit low");
    a0 = acc_m; b0 = brk_cnt_m;
    applyStimulus(0, 9'h03C, 8, -1, 1, 2'b00, -1);
    idle_bits(0, 2);
    checkOutput("ferr_accepts", 16'(acc_m - a0), 16'd1);
    checkOutput("ferr_data", 16'(last_d_m), 16'h003C);
    checkOutput("ferr_flag", 16'(last_fe_m), 16'h0001);
    checkOutput("ferr_no_break", 16'(brk_cnt_m - b0), 16'd0);

    $display("[TB] line held low for 20 bits");
    a0 = acc_m; b0 = brk_cnt_m; v0 = vhi_m;
    for (int i = 0; i < 20; i++) hold_bit(0, 1'b0, 1'b0);
    checkOutput("break_pulses", 16'(brk_cnt_m - b0), 16'd1);
    checkOutput("break_no_valid", 16'(vhi_m - v0), 16'd0);
    checkOutput("break_state", 16'(u_main.state), 16'(ST_BREAK));
    idle_bits(0, 1);
    checkOutput("break_exit_idle", 16'(u_main.state), 16'(ST_IDLE));
    applyStimulus(0, 9'h055, 8, -1, 1, 2'b11, -1);
    idle_bits(0, 1);
    checkOutput("post_break_data", 16'(last_d_m), 16'h0055);
    checkOutput("post_break_flags", 16'({last_pe_m, last_fe_m}), 16'h0000);

    $display("[TB] 0x11 then 0x22 with ready low");
    ready_m = 1'b0;
    a0 = acc_m; o0 = ovr_cnt_m;
    applyStimulus(0, 9'h011, 8, -1, 1, 2'b11, -1);
    applyStimulus(0, 9'h022, 8, -1, 1, 2'b11, -1);
    idle_bits(0, 1);
    checkOutput("ovr_valid_held", 16'(valid_m), 16'h0001);
    checkOutput("ovr_data_held", 16'(data_m), 16'h0011);
    checkOutput("ovr_pulses", 16'(ovr_cnt_m - o0), 16'd1);
    @(posedge clk);
    #2 ready_m = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("ovr_accepts", 16'(acc_m - a0), 16'd1);
    checkOutput("ovr_accepted_data", 16'(last_d_m), 16'h0011);
    checkOutput("ovr_valid_cleared", 16'(valid_m), 16'h0000);

    $display("[TB] even parity instance");
    ap0 = acc_p;
    applyStimulus(1, 9'h007, 8, 0, 1, 2'b11, -1);
    idle_bits(1, 1);
    checkOutput("par_bad_data", 16'(last_d_p), 16'h0007);
    checkOutput("par_bad_flag", 16'(last_pe_p), 16'h0001);
    checkOutput("par_bad_no_ferr", 16'(last_fe_p), 16'h0000);
    applyStimulus(1, 9'h003, 8, 0, 1, 2'b11, -1);
    idle_bits(1, 1);
    checkOutput("par_good_data", 16'(last_d_p), 16'h0003);
    checkOutput("par_good_flag", 16'(last_pe_p), 16'h0000);
    checkOutput("par_accepts", 16'(acc_p - ap0), 16'd2);

    $display("[TB] 5 data bits, 2 stop bits");
    af0 = acc_f;
    applyStimulus(2, 9'h015, 5, -1, 2, 2'b11, -1);
    idle_bits(2, 1);
    checkOutput("five_data", 16'(last_d_f), 16'h0015);
    checkOutput("five_no_ferr", 16'(last_fe_f), 16'h0000);
    applyStimulus(2, 9'h00A, 5, -1, 2, 2'b01, -1);
    idle_bits(2, 1);
    checkOutput("five_second_stop_data", 16'(last_d_f), 16'h000A);
    checkOutput("five_second_stop_ferr", 16'(last_fe_f), 16'h0001);
    checkOutput("five_accepts", 16'(acc_f - af0), 16'd2);

    $display("[TB] reset during bit 4 of 0x9C");
    hold_bit(0, 1'b0, 1'b0);
    hold_bit(0, 1'b0, 1'b0);
    hold_bit(0, 1'b0, 1'b0);
    hold_bit(0, 1'b1, 1'b0);
    hold_bit(0, 1'b1, 1'b0);
    rx_m = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset_data", 16'(data_m), 16'h0000);
    checkOutput("midreset_valid", 16'(valid_m), 16'h0000);
    checkOutput("midreset_flags", 16'({pe_m, fe_m, ovr_m, brk_m}), 16'h0000);
    checkOutput("midreset_state", 16'(u_main.state), 16'(ST_IDLE));
    rst = 1'b1;
    idle_bits(0, 2);
    a0 = acc_m;
    applyStimulus(0, 9'h09C, 8, -1, 1, 2'b11, -1);
    idle_bits(0, 1);
    checkOutput("after_reset_accepts", 16'(acc_m - a0), 16'd1);
    checkOutput("after_reset_data", 16'(last_d_m), 16'h009C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
